// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a fetch port and a data port onto one single-ported
//               memory with combinational read data. At most one access is
//               issued per cycle. Data normally wins contention. Fetch wins
//               once it has been denied MAX_WAIT cycles in a row. Read data
//               is registered and returned one cycle after the grant.
//               Out-of-range accesses drop the write, return zero data and
//               pulse err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   i_req, i_addr                 fetch request and byte address
//   i_gnt, i_rvalid, i_rdata      fetch grant, response valid, response data
//   d_req, d_we, d_addr, d_wdata  data request, store flag, address and data
//   d_gnt, d_rvalid, d_rdata      data grant, load valid, load data
//   mem_we, mem_addr, mem_wdata   memory write enable, address, write data
//   mem_rdata                     memory read data (combinational)
//   err                           one-cycle pulse after an out-of-range access
//   waiting                       fetch starvation counter (debug)
// ============================================================================
module mem_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int DEPTH    = 51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic [2:0]  waiting
);

  // The starvation counter is 3 bits wide, so MAX_WAIT must not exceed 7.
  localparam logic [2:0]  c_max_wait = 3'(MAX_WAIT);
  localparam logic [31:0] c_depth    = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSP_I = 2'd1,
    RSP_D = 2'd2
  } rsp_state_e;

  rsp_state_e  state_q, state_d;
  logic [2:0]  waiting_q, waiting_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  logic        fetch_gnt;
  logic        data_gnt;
  logic [31:0] sel_addr;
  logic        in_range;
  logic [31:0] rd_word;

  // Grant decision and memory-side address mux.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    // Grants are held off while reset is asserted, so nothing is issued
    // until reset is released.
    if (!reset) begin
      if (i_req && (!d_req || (waiting_q >= c_max_wait))) begin
        fetch_gnt = 1'b1;
      end else if (d_req) begin
        data_gnt = 1'b1;
      end
    end

    sel_addr = 32'd0;
    if (fetch_gnt) begin
      sel_addr = i_addr;
    end else if (data_gnt) begin
      sel_addr = d_addr;
    end

    // Only bits [22:2] form the word index. Higher address bits are ignored.
    in_range = ({11'd0, sel_addr[22:2]} < c_depth);
    rd_word  = in_range ? mem_rdata : 32'd0;
  end

  // Next-state logic for the starvation counter, response FSM and read data.
  always_comb begin
    waiting_d = waiting_q;
    if (!i_req || fetch_gnt) begin
      waiting_d = 3'd0;
    end else if (waiting_q < c_max_wait) begin
      waiting_d = waiting_q + 3'd1;
    end

    state_d = IDLE;
    if (fetch_gnt) begin
      state_d = RSP_I;
    end else if (data_gnt && !d_we) begin
      state_d = RSP_D;
    end

    // Each rdata register loads only on its own read grant. Otherwise it
    // keeps its last value.
    i_rdata_d = fetch_gnt ? rd_word : i_rdata_q;
    d_rdata_d = (data_gnt && !d_we) ? rd_word : d_rdata_q;

    err_d = (fetch_gnt || data_gnt) && !in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waiting_q <= 3'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waiting_q <= waiting_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign i_gnt     = fetch_gnt;
  assign d_gnt     = data_gnt;
  assign mem_addr  = sel_addr;
  assign mem_wdata = data_gnt ? d_wdata : 32'd0;
  assign mem_we    = data_gnt && d_we && in_range;

  assign i_rvalid  = (state_q == RSP_I);
  assign d_rvalid  = (state_q == RSP_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign waiting   = waiting_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Contains a behavioural
//               memory, a reference arbitration model and a response
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int MAX_WAIT = 3;
  localparam int DEPTH    = 51;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  waiting;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err(err), .waiting(waiting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hEF20_2001 : (32'h5A00_0000 ^ (i * 32'h0101_0101));
  endfunction

  // Behavioural memory with combinational read data. Reads beyond DEPTH
  // return garbage, so the DUT must zero them itself.
  logic [31:0] mem [DEPTH];
  logic        mem_init_done = 1'b0;
  int          mem_idx;
  assign mem_idx = int'(mem_addr[22:2]);
  always_comb mem_rdata = (mem_idx < DEPTH) ? mem[mem_idx] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_we && mem_idx < DEPTH) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // Reference model and scoreboard.
  typedef struct packed {
    int          due;
    logic [1:0]  port;   // 0 = none (error only), 1 = fetch, 2 = data
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  logic        ref_init = 1'b0;
  logic [2:0]  m_wait;
  logic [31:0] exp_irdata, exp_drdata;

  always @(negedge clk) begin
    logic        ei, ed, inr, eiv, edv, eerr;
    logic [31:0] eaddr, rdv;
    int          idx;
    rsp_t        r;
    cyc++;
    if (!ref_init) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (reset) begin
      chk("rst_gnt",   {30'd0, i_gnt, d_gnt}, 32'd0);
      chk("rst_valid", {29'd0, i_rvalid, d_rvalid, err}, 32'd0);
      chk("rst_irdata", i_rdata, 32'd0);
      chk("rst_drdata", d_rdata, 32'd0);
      chk("rst_mem",   {31'd0, mem_we} | mem_addr, 32'd0);
      chk("rst_wait",  {29'd0, waiting}, 32'd0);
      sb.delete();
      m_wait     = 3'd0;
      exp_irdata = 32'd0;
      exp_drdata = 32'd0;
    end else begin
      ei    = i_req && (!d_req || m_wait == 3'(MAX_WAIT));
      ed    = d_req && !ei;
      eaddr = ei ? i_addr : (ed ? d_addr : 32'd0);
      idx   = int'(eaddr[22:2]);
      inr   = idx < DEPTH;
      rdv   = inr ? ref_mem[idx] : 32'd0;

      chk("gnt",      {30'd0, i_gnt, d_gnt}, {30'd0, ei, ed});
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_we",   {31'd0, mem_we}, {31'd0, ed && d_we && inr});
      if (mem_we) chk("mem_wdata", mem_wdata, d_wdata);
      chk("waiting",  {29'd0, waiting}, {29'd0, m_wait});

      eiv = 1'b0; edv = 1'b0; eerr = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r    = sb.pop_front();
        eiv  = (r.port == 2'd1);
        edv  = (r.port == 2'd2);
        eerr = r.err;
        if (eiv) exp_irdata = r.data;
        if (edv) exp_drdata = r.data;
      end
      chk("rvalid_err", {29'd0, i_rvalid, d_rvalid, err}, {29'd0, eiv, edv, eerr});
      chk("i_rdata", i_rdata, exp_irdata);
      chk("d_rdata", d_rdata, exp_drdata);

      if (ei) sb.push_back('{due: cyc + 1, port: 2'd1, data: rdv, err: !inr});
      else if (ed && !d_we) sb.push_back('{due: cyc + 1, port: 2'd2, data: rdv, err: !inr});
      else if (ed && !inr) sb.push_back('{due: cyc + 1, port: 2'd0, data: 32'd0, err: 1'b1});

      if (ed && d_we && inr) ref_mem[idx] = d_wdata;
      if (!i_req || ei) m_wait = 3'd0;
      else if (m_wait < 3'(MAX_WAIT)) m_wait = m_wait + 3'd1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [8:0]  hi;
    logic [20:0] ix;
    hi = 9'($urandom);
    ix = 21'($urandom_range(0, 55));
    return {hi, ix, 2'b00};
  endfunction

  initial begin
    logic ig, dg;
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    step(3);
    reset = 1'b0;

    // Fetch only.
    i_req = 1'b1; i_addr = 32'h8;
    step(1);
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_word2", i_rdata, 32'hEF20_2001);
    step(1);

    // Store followed directly by a load of the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    step(1);
    d_we = 1'b0;
    step(1);
    d_req = 1'b0;
    @(negedge clk);
    chk("store_load", d_rdata, 32'hDEAD_BEEF);
    step(1);

    // Continuous contention.
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    step(9);
    i_req = 1'b0; d_req = 1'b0;
    step(2);

    // Range boundaries, including ignored upper address bits.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC8;   step(1);  // index 50
    d_addr = 32'hCC;                               step(1);  // index 51
    d_addr = 32'h100;                              step(1);  // index 64
    d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678; step(1);
    d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_addr = 32'h200;                step(1);
    i_addr = 32'h8000_0008;                        step(1);
    i_req = 1'b0;
    step(1);

    // Idle period.
    step(10);

    // Reset during an outstanding fetch. Reset deasserts together with a
    // request, so a grant is possible on the very next edge.
    i_req = 1'b1; i_addr = 32'hC;
    @(negedge clk);
    #1 reset = 1'b1;
    step(2);
    reset = 1'b0; i_addr = 32'h8;
    step(1);
    i_req = 1'b0;
    step(2);

    // Random traffic. Requesters hold their request until it is granted.
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      @(posedge clk);
      #1;
      if (!i_req || ig) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = rand_addr();
      end
      if (!d_req || dg) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
